// File: rtl/bus_reg_file.sv
// Purpose : DEPTH x WIDTH register bank sharing one tri-state bus (load, drive, increment, clear).
// Latency : writes/inc/clr commit at the request edge; read data appears on bus one cycle after rd_en.
// Backpressure: none; one operation per cycle, illegal combinations are dropped and flagged in err.
module bus_reg_file #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter int               ADDR_W    = $clog2(DEPTH),
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic              clock,
  input  logic              n_reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic              inc_en,
  input  logic              clr_en,
  input  logic              err_clr,
  inout  wire  [WIDTH-1:0]  bus,
  output logic              drive,
  output logic              carry,
  output logic              zero,
  output logic              err
);

  // DEPTH widened by one bit so addr >= DEPTH is detectable even when DEPTH == 2**ADDR_W
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [WIDTH-1:0] out_data;
  logic [WIDTH-1:0] rd_data;
  logic [WIDTH-1:0] inc_val;
  logic [DEPTH-1:0] sel;
  logic [3:0]       op_vec;
  logic             op_any;
  logic             op_multi;
  logic             addr_ok;
  logic             op_illegal;
  logic             op_ok;
  logic             do_wr;
  logic             do_rd;
  logic             do_inc;
  logic             do_clr;
  logic             drive_nxt;
  logic             carry_nxt;
  logic             zero_nxt;
  logic             err_nxt;

  // The block only ever owns the bus while its registered drive flag is set
  assign bus = drive ? out_data : 'z;

  // Operation decode: exactly one enable and an in-range address make a legal operation
  always_comb begin
    op_vec     = {wr_en, rd_en, inc_en, clr_en};
    op_any     = |op_vec;
    op_multi   = (op_vec & (op_vec - 4'd1)) != 4'd0;
    addr_ok    = {1'b0, addr} < DEPTH_EXT;
    op_illegal = op_multi || (op_any && !addr_ok);
    op_ok      = op_any && !op_illegal;
    do_wr      = op_ok && wr_en;
    do_rd      = op_ok && rd_en;
    do_inc     = op_ok && inc_en;
    do_clr     = op_ok && clr_en;
  end

  // One-hot register select and read mux; out-of-range addresses select nothing
  always_comb begin
    sel     = '0;
    rd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addr == ADDR_W'(i)) begin
        sel[i]  = 1'b1;
        rd_data = regs[i];
      end
    end
    inc_val = rd_data + WIDTH'(1);
  end

  // Next values of the status outputs; zero/err hold unless an operation updates them
  always_comb begin
    drive_nxt = do_rd;
    carry_nxt = do_inc && (&rd_data);
    zero_nxt  = zero;
    if (do_wr)  zero_nxt = (bus == '0);
    if (do_rd)  zero_nxt = (rd_data == '0);
    if (do_inc) zero_nxt = (inc_val == '0);
    if (do_clr) zero_nxt = (RESET_VAL == '0);
    // a new illegal operation outranks a simultaneous clear request
    if (op_illegal)   err_nxt = 1'b1;
    else if (err_clr) err_nxt = 1'b0;
    else              err_nxt = err;
  end

  // Register array: flops, updated only for the selected entry of a legal op
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= RESET_VAL;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (sel[i]) begin
          if (do_wr)       regs[i] <= bus;
          else if (do_inc) regs[i] <= inc_val;
          else if (do_clr) regs[i] <= RESET_VAL;
        end
      end
    end
  end

  // Output data latch feeding the bus; refreshed every read cycle so addr changes follow
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset)   out_data <= '0;
    else if (do_rd) out_data <= rd_data;
  end

  // Status flags; reset drops drive at once so a read in progress releases the bus
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      drive <= 1'b0;
      carry <= 1'b0;
      zero  <= 1'b0;
      err   <= 1'b0;
    end else begin
      drive <= drive_nxt;
      carry <= carry_nxt;
      zero  <= zero_nxt;
      err   <= err_nxt;
    end
  end

endmodule

// File: tb/tb_bus_reg_file.sv
// Bench for bus_reg_file with DEPTH=5 (3-bit address) and a non-zero reset value.
module tb_bus_reg_file;

  localparam int          W    = 8;
  localparam int          D    = 5;
  localparam int          AW   = 3;
  localparam logic [7:0]  RV   = 8'h5A;
  localparam logic [3:0]  IDLE = 4'b0000;
  localparam logic [3:0]  WR   = 4'b1000;
  localparam logic [3:0]  RD   = 4'b0100;
  localparam logic [3:0]  INC  = 4'b0010;
  localparam logic [3:0]  CLR  = 4'b0001;

  logic          clock = 1'b0;
  logic          n_reset;
  logic [AW-1:0] addr;
  logic          wr_en, rd_en, inc_en, clr_en, err_clr;
  wire  [W-1:0]  bus;
  logic          drive, carry, zero, err;
  logic          tb_en;
  logic [W-1:0]  tb_dat;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [2:0] a;
    logic [3:0] op;
    logic       ec;
    logic [7:0] wd;
    logic       xd;
    logic [7:0] xb;
    logic       xc;
    logic       xz;
    logic       xe;
  } vec_t;

  vec_t vq[$];

  assign bus = tb_en ? tb_dat : 'z;

  bus_reg_file #(.WIDTH(W), .DEPTH(D), .RESET_VAL(RV)) dut (
    .clock(clock), .n_reset(n_reset), .addr(addr),
    .wr_en(wr_en), .rd_en(rd_en), .inc_en(inc_en), .clr_en(clr_en),
    .err_clr(err_clr), .bus(bus),
    .drive(drive), .carry(carry), .zero(zero), .err(err)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Apply one operation for one clock, then settle just after the edge
  task automatic step(input logic [2:0] a, input logic [3:0] op, input logic ec, input logic [7:0] wd);
    addr = a;
    {wr_en, rd_en, inc_en, clr_en} = op;
    err_clr = ec;
    tb_dat  = wd;
    tb_en   = (op == WR);
    @(posedge clock);
    #1;
  endtask

  task automatic add(input logic [2:0] a, input logic [3:0] op, input logic ec, input logic [7:0] wd,
                     input logic xd, input logic [7:0] xb, input logic xc, input logic xz, input logic xe);
    vec_t v;
    v.a = a; v.op = op; v.ec = ec; v.wd = wd;
    v.xd = xd; v.xb = xb; v.xc = xc; v.xz = xz; v.xe = xe;
    vq.push_back(v);
  endtask

  initial begin
    // a     op         ec    wd     drv   bus    carry zero  err
    add(3'd2, WR,        1'b0, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0); // write A5 to r2
    add(3'd2, RD,        1'b0, 8'h00, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0); // read-after-write
    add(3'd0, IDLE,      1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0); // drive drops
    add(3'd1, WR,        1'b0, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    add(3'd1, INC,       1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0); // FF -> 00 wraps
    add(3'd1, INC,       1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0); // 00 -> 01
    add(3'd1, RD,        1'b0, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
    add(3'd0, IDLE,      1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    add(3'd0, WR,        1'b0, 8'h3C, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    add(3'd0, RD,        1'b0, 8'h00, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    add(3'd0, WR|RD,     1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1); // illegal combo
    add(3'd0, IDLE,      1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1); // err sticky
    add(3'd0, RD,        1'b0, 8'h00, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b1); // r0 unchanged
    add(3'd0, IDLE,      1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0); // err_clr
    add(3'd4, WR,        1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0); // zero from bus
    add(3'd6, WR,        1'b0, 8'h77, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1); // out of range
    add(3'd4, RD,        1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1); // r4 valid read
    add(3'd0, RD,        1'b0, 8'h00, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b1);
    add(3'd1, RD,        1'b0, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, 1'b1);
    add(3'd2, RD,        1'b0, 8'h00, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1);
    add(3'd3, RD,        1'b0, 8'h00, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b1);
    add(3'd4, RD,        1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1);
    add(3'd3, INC|CLR,   1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1); // set beats clear
    add(3'd0, IDLE,      1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    add(3'd3, RD,        1'b0, 8'h00, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0); // r3 unchanged
    add(3'd2, CLR,       1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0); // r2 <- 5A
    add(3'd2, RD,        1'b0, 8'h00, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
    add(3'd0, IDLE,      1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    add(3'd0, WR,        1'b0, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    add(3'd1, WR,        1'b0, 8'h02, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    add(3'd2, WR,        1'b0, 8'h03, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    add(3'd3, WR,        1'b0, 8'h04, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    add(3'd0, RD,        1'b0, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0); // streaming reads
    add(3'd1, RD,        1'b0, 8'h00, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
    add(3'd2, RD,        1'b0, 8'h00, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
    add(3'd3, RD,        1'b0, 8'h00, 1'b1, 8'h04, 1'b0, 1'b0, 1'b0);
    add(3'd0, IDLE,      1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    add(3'd5, RD,        1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1); // out-of-range read
    add(3'd0, IDLE,      1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Power-up reset
    n_reset = 1'b0; addr = '0; wr_en = 0; rd_en = 0; inc_en = 0; clr_en = 0;
    err_clr = 0; tb_en = 0; tb_dat = '0;
    repeat (2) @(posedge clock);
    #1;
    check("reset.drive", {7'd0, drive}, 8'd0);
    check("reset.carry", {7'd0, carry}, 8'd0);
    check("reset.zero",  {7'd0, zero},  8'd0);
    check("reset.err",   {7'd0, err},   8'd0);
    @(negedge clock);
    n_reset = 1'b1;
    @(posedge clock);
    #1;

    // Table of single-cycle operations
    foreach (vq[i]) begin
      step(vq[i].a, vq[i].op, vq[i].ec, vq[i].wd);
      check($sformatf("v%0d.drive", i), {7'd0, drive}, {7'd0, vq[i].xd});
      check($sformatf("v%0d.carry", i), {7'd0, carry}, {7'd0, vq[i].xc});
      check($sformatf("v%0d.zero", i),  {7'd0, zero},  {7'd0, vq[i].xz});
      check($sformatf("v%0d.err", i),   {7'd0, err},   {7'd0, vq[i].xe});
      if (vq[i].xd) check($sformatf("v%0d.bus", i), bus, vq[i].xb);
    end

    // Asynchronous reset in the middle of a read releases the bus at once
    step(3'd1, WR|RD, 1'b0, 8'h00);
    check("pre_rst.err", {7'd0, err}, 8'd1);
    step(3'd2, RD, 1'b0, 8'h00);
    check("pre_rst.drive", {7'd0, drive}, 8'd1);
    check("pre_rst.bus", bus, 8'h03);
    #2;
    n_reset = 1'b0;
    #1;
    check("mid_rst.drive", {7'd0, drive}, 8'd0);
    check("mid_rst.err",   {7'd0, err},   8'd0);
    check("mid_rst.zero",  {7'd0, zero},  8'd0);
    @(posedge clock);
    #1;
    check("held_rst.drive", {7'd0, drive}, 8'd0);
    @(negedge clock);
    rd_en = 1'b0;
    n_reset = 1'b1;
    @(posedge clock);
    #1;

    // Every register back at the reset value
    for (int r = 0; r < D; r++) begin
      step(3'(r), RD, 1'b0, 8'h00);
      check($sformatf("post_rst.r%0d.drive", r), {7'd0, drive}, 8'd1);
      check($sformatf("post_rst.r%0d.bus", r), bus, RV);
    end
    step(3'd0, IDLE, 1'b0, 8'h00);
    check("post_rst.release", {7'd0, drive}, 8'd0);
    check("post_rst.err", {7'd0, err}, 8'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, limit 100000");
    $fatal(1);
  end

endmodule
